// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC frame capture block.
// The optional level trigger is enabled by defining ADC_FRAME_TRIG_EN.
package adc_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

    localparam int FRAME_LEN_DEF    = 1024;
    localparam int TRIG_TIMEOUT_DEF = 65535;

    // True when the FIFO has strictly more free words than one full frame.
    function automatic logic fifo_has_room(input int depth, input int count, input int len);
        return (depth - count) > len;
    endfunction

endpackage

// File: rtl/adc_frame_capture_if.sv
// FIFO write-port bundle between the frame capture stage and the sample FIFO.
interface adc_frame_capture_if #(
    parameter int OUT_W = 8,
    parameter int CNT_W = 13
);
    logic             fifo_wr_en;
    logic [OUT_W-1:0] fifo_din;
    logic [CNT_W-1:0] fifo_wr_count;

    modport master (output fifo_wr_en, output fifo_din, input  fifo_wr_count);
    modport slave  (input  fifo_wr_en, input  fifo_din, output fifo_wr_count);
endinterface

// File: rtl/adc_trig_detect.sv
// Rising-edge level trigger with a watchdog that forces a start when no
// edge arrives. Only instantiated when ADC_FRAME_TRIG_EN is defined.
// The edge compare looks at the live pin sample so that the sample which
// fires the trigger is still in the input register when capture begins.
module adc_trig_detect
    import adc_cap_pkg::*;
#(
    parameter int OUT_W        = 8,
    parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [OUT_W-1:0] sample,
    input  logic [OUT_W-1:0] level,
    output logic             trig_hit,
    output logic             trig_to
);
    localparam int TO_W = $clog2(TRIG_TIMEOUT + 1);

    logic [OUT_W-1:0] prev_reg;
    logic [TO_W-1:0]  to_cnt_reg;

    // Previous upper-bits sample, tracked on every cycle regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_reg <= '0;
        else     prev_reg <= sample;
    end

    // Cycles spent waiting; restarts whenever the wait state is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      to_cnt_reg <= '0;
        else if (!en) to_cnt_reg <= '0;
        else          to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end

    assign trig_hit = en && (prev_reg < level) && (sample >= level);
    assign trig_to  = en && (to_cnt_reg == TO_W'(TRIG_TIMEOUT - 1));

endmodule

// File: rtl/adc_frame_capture.sv
// ADC frame capture: registers the ADC pins, waits for FIFO room (and the
// optional level trigger, macro ADC_FRAME_TRIG_EN), then writes one
// decimated frame of FRAME_LEN samples into the downstream FIFO.
module adc_frame_capture
    import adc_cap_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int OUT_W        = 8,
    parameter int FIFO_DEPTH   = 8192,
    parameter int CNT_W        = 13,
    parameter int FRAME_LEN    = FRAME_LEN_DEF,
    parameter int DECIM_W      = 8,
    parameter int TRIG_TIMEOUT = TRIG_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  ad_data,
    input  logic               ad_otr,
    input  logic               frame_req,
    input  logic [DECIM_W-1:0] decim,
    input  logic [OUT_W-1:0]   trig_level,
    adc_frame_capture_if.master fifo,
    output logic               busy,
    output logic               frame_done,
    output logic               otr_flag,
    output logic               trig_timeout
);
    cap_state_t         state_reg;
    logic [DATA_W-1:0]  ad_q_reg;
    logic               otr_q_reg;
    logic [DECIM_W-1:0] decim_reg;
    logic [DECIM_W-1:0] d_reg;
    logic [CNT_W-1:0]   n_reg;
    logic               wr_en_reg;
    logic [OUT_W-1:0]   din_reg;
    logic               busy_reg;
    logic               frame_done_reg;
    logic               otr_flag_reg;
    logic [OUT_W-1:0]   sample_up;

    assign sample_up = ad_q_reg[DATA_W-1 -: OUT_W];

    generate
        if (DATA_W > OUT_W) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^ad_q_reg[DATA_W-OUT_W-1:0];
        end
    endgenerate

`ifdef ADC_FRAME_TRIG_EN
    logic trig_hit;
    logic trig_to;
    logic trig_timeout_reg;

    adc_trig_detect #(
        .OUT_W        (OUT_W),
        .TRIG_TIMEOUT (TRIG_TIMEOUT)
    ) u_trig (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg == ST_WAIT_TRIG),
        .sample   (ad_data[DATA_W-1 -: OUT_W]),
        .level    (trig_level),
        .trig_hit (trig_hit),
        .trig_to  (trig_to)
    );

    assign trig_timeout = trig_timeout_reg;
`else
    logic unused_trig;
    assign unused_trig  = ^trig_level;
    assign trig_timeout = 1'b0;
`endif

    // Single input register stage for the ADC word and its over-range bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ad_q_reg  <= '0;
            otr_q_reg <= 1'b0;
        end else begin
            ad_q_reg  <= ad_data;
            otr_q_reg <= ad_otr;
        end
    end

    // Frame sequencer with registered FIFO write port and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            decim_reg        <= '0;
            d_reg            <= '0;
            n_reg            <= '0;
            wr_en_reg        <= 1'b0;
            din_reg          <= '0;
            busy_reg         <= 1'b0;
            frame_done_reg   <= 1'b0;
            otr_flag_reg     <= 1'b0;
`ifdef ADC_FRAME_TRIG_EN
            trig_timeout_reg <= 1'b0;
`endif
        end else begin
            wr_en_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (frame_req) begin
                        state_reg <= ST_ARM;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (fifo_has_room(FIFO_DEPTH, int'(fifo.fifo_wr_count), FRAME_LEN)) begin
`ifdef ADC_FRAME_TRIG_EN
                        state_reg <= ST_WAIT_TRIG;
`else
                        state_reg    <= ST_CAPTURE;
                        decim_reg    <= decim;
                        d_reg        <= '0;
                        n_reg        <= '0;
                        otr_flag_reg <= 1'b0;
`endif
                    end
                end
                ST_WAIT_TRIG: begin
`ifdef ADC_FRAME_TRIG_EN
                    if (trig_hit || trig_to) begin
                        state_reg        <= ST_CAPTURE;
                        decim_reg        <= decim;
                        d_reg            <= '0;
                        n_reg            <= '0;
                        otr_flag_reg     <= 1'b0;
                        trig_timeout_reg <= !trig_hit;
                    end
`else
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
`endif
                end
                ST_CAPTURE: begin
                    if (d_reg == '0) begin
                        wr_en_reg <= 1'b1;
                        din_reg   <= sample_up;
                        n_reg     <= n_reg + CNT_W'(1);
                        if (otr_q_reg)
                            otr_flag_reg <= 1'b1;
                        if (n_reg == CNT_W'(FRAME_LEN - 1))
                            state_reg <= ST_DONE;
                    end
                    d_reg <= (d_reg == decim_reg) ? '0 : d_reg + DECIM_W'(1);
                end
                ST_DONE: begin
                    frame_done_reg <= 1'b1;
                    busy_reg       <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_wr_en = wr_en_reg;
    assign fifo.fifo_din   = din_reg;
    assign busy            = busy_reg;
    assign frame_done      = frame_done_reg;
    assign otr_flag        = otr_flag_reg;

endmodule

// File: tb/tb_adc_frame_capture.sv
// Self-checking bench for adc_frame_capture. The reference model predicts
// each cycle's outputs from the sample history using timing arithmetic:
// the first written sample is the pin value in the cycle the frame start
// condition is met, later writes follow every decim+1 samples, and the
// outputs appear two cycles after the pin. Trigger scenarios run when the
// bench is built with ADC_FRAME_TRIG_EN.
module tb_adc_frame_capture;

    localparam int DATA_W       = 10;
    localparam int OUT_W        = 8;
    localparam int FIFO_DEPTH   = 8192;
    localparam int CNT_W        = 13;
    localparam int FRAME_LEN    = 16;
    localparam int DECIM_W      = 8;
    localparam int TRIG_TIMEOUT = 65535;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_W-1:0]  ad_data;
    logic               ad_otr;
    logic               frame_req;
    logic [DECIM_W-1:0] decim;
    logic [OUT_W-1:0]   trig_level;
    logic               busy;
    logic               frame_done;
    logic               otr_flag;
    logic               trig_timeout;

    adc_frame_capture_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) fifo_bus ();

    adc_frame_capture #(
        .DATA_W       (DATA_W),
        .OUT_W        (OUT_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CNT_W        (CNT_W),
        .FRAME_LEN    (FRAME_LEN),
        .DECIM_W      (DECIM_W),
        .TRIG_TIMEOUT (TRIG_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ad_data      (ad_data),
        .ad_otr       (ad_otr),
        .frame_req    (frame_req),
        .decim        (decim),
        .trig_level   (trig_level),
        .fifo         (fifo_bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .otr_flag     (otr_flag),
        .trig_timeout (trig_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int               t;
    int               s_cyc;      // cycle of the first written pin sample, -1 if not started
    int               d_val;
    int               l_cyc;      // cycle in which the last write is visible
    int               act_from;
    int               act_to;
    int               arm_from;
    int               wait_from;
    bit               arming;
    bit               waiting;
    bit               s_by_to;
    logic             exp_otr;
    logic             exp_to;
    logic [OUT_W-1:0] up_d1;
    logic [OUT_W-1:0] up_d2;
    logic             otr_d1;
    logic             otr_d2;
    int               frames_exp;
    int               done_seen;
    int               wr_frame;
    bit               first_chk_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, t);
        end
    endtask

    task automatic model_reset();
        s_cyc = -1; d_val = 0; l_cyc = 0; act_from = -1; act_to = -1;
        arm_from = 0; wait_from = 0; arming = 0; waiting = 0; s_by_to = 0;
        exp_otr = 1'b0; exp_to = 1'b0;
        up_d1 = '0; up_d2 = '0; otr_d1 = 1'b0; otr_d2 = 1'b0;
        wr_frame = 0;
    endtask

    task automatic model_start(input bit by_to, input logic [DECIM_W-1:0] dc);
        s_cyc   = t;
        d_val   = int'(dc);
        s_by_to = by_to;
        l_cyc   = s_cyc + 2 + (FRAME_LEN - 1) * (d_val + 1);
        act_to  = l_cyc;
        arming  = 0;
        waiting = 0;
    endtask

    // Check the current cycle, drive inputs for it, update the model, advance.
    task automatic step(input logic [DATA_W-1:0] dv, input logic ov, input logic rq,
                        input logic [DECIM_W-1:0] dc, input logic [CNT_W-1:0] cn);
        logic             exp_wr;
        logic             exp_done;
        logic             exp_busy;
        logic [OUT_W-1:0] cur_up;
        int               koff;
        bit               hit;
        bit               tmo;
        exp_wr   = 1'b0;
        exp_done = 1'b0;
        if (s_cyc >= 0) begin
            koff = t - (s_cyc + 2);
            if (koff >= 0 && (koff % (d_val + 1)) == 0 && (koff / (d_val + 1)) < FRAME_LEN)
                exp_wr = 1'b1;
            if (t == l_cyc + 1) exp_done = 1'b1;
            if (t == s_cyc + 1) begin
                exp_otr = 1'b0;
                exp_to  = s_by_to;
            end
        end
        if (exp_wr && otr_d2) exp_otr = 1'b1;
        exp_busy = (act_from >= 0) && (t >= act_from) && (t <= act_to);

        chk("busy", 32'(busy), 32'(exp_busy));
        chk("wr_en", 32'(fifo_bus.fifo_wr_en), 32'(exp_wr));
        chk("frame_done", 32'(frame_done), 32'(exp_done));
        chk("otr_flag", 32'(otr_flag), 32'(exp_otr));
        chk("trig_timeout", 32'(trig_timeout), 32'(exp_to));
        if (exp_wr) chk("din", 32'(fifo_bus.fifo_din), 32'(up_d2));
        if (first_chk_en && exp_wr && t == s_cyc + 2)
            chk("first_trig_din", 32'(fifo_bus.fifo_din >= trig_level), 32'd1);

        if (fifo_bus.fifo_wr_en) wr_frame++;
        if (frame_done) begin
            done_seen++;
            $display("frame %0d done cycle=%0d writes=%0d decim=%0d otr=%0b trig_timeout=%0b",
                     done_seen, t, wr_frame, d_val, otr_flag, trig_timeout);
        end
        if (exp_done) frames_exp++;

        ad_data   = dv;
        ad_otr    = ov;
        frame_req = rq;
        decim     = dc;
        fifo_bus.fifo_wr_count = cn;
        cur_up = dv[DATA_W-1 -: OUT_W];

        if (!exp_busy && rq) begin
            act_from = t + 1; act_to = 32'h7fffffff; s_cyc = -1;
            arming = 1; arm_from = t + 1; waiting = 0; wr_frame = 0;
        end else if (arming && t >= arm_from && (FIFO_DEPTH - int'(cn)) > FRAME_LEN) begin
`ifdef ADC_FRAME_TRIG_EN
            waiting = 1; wait_from = t + 1; arming = 0;
`else
            model_start(1'b0, dc);
`endif
        end else if (waiting && t >= wait_from) begin
            hit = (up_d1 < trig_level) && (cur_up >= trig_level);
            tmo = (t - wait_from) == (TRIG_TIMEOUT - 1);
            if (hit || tmo) model_start(!hit, dc);
        end

        @(posedge clk);
        #1;
        t++;
        up_d2 = up_d1; up_d1 = cur_up;
        otr_d2 = otr_d1; otr_d1 = ov;
    endtask

    // mode: 0 ramp, 1 random, 2 sine, 3 DC level 0x10 in the upper bits.
    // otr_k >= 0 marks only written sample otr_k, -2 random OTR, -1 none.
    task automatic run_frame(input int mode, input logic [DECIM_W-1:0] dc, input int otr_k,
                             input bit rereq, input int hold, input int budget, input bit must_finish);
        int f0;
        int i;
        logic [DATA_W-1:0] dv;
        logic ov;
        logic rq;
        logic [CNT_W-1:0] cn;
        f0 = frames_exp;
        i = 0;
        first_chk_en = (mode == 2);
        while (i < budget && frames_exp == f0) begin
            case (mode)
                0:       dv = DATA_W'((i == 0) ? 0 : (i - 1) * 4);
                1:       dv = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
                2:       dv = DATA_W'(512 + int'(450.0 * $sin(6.2831853 * real'(i) / 23.0)));
                default: dv = DATA_W'(16 * 4);
            endcase
            if (otr_k >= 0)       ov = (s_cyc >= 0) && (t == s_cyc + otr_k * (d_val + 1));
            else if (otr_k == -2) ov = ($urandom_range(0, 7) == 0);
            else                  ov = 1'b0;
            rq = (i == 0) || (rereq && (i % 5) == 0);
            if (i < hold / 2)  cn = CNT_W'(8180);
            else if (i < hold) cn = CNT_W'(8176);
            else if (hold > 0) cn = CNT_W'(8175);
            else               cn = CNT_W'($urandom_range(0, 8000));
            step(dv, ov, rq, dc, cn);
            i++;
        end
        first_chk_en = 0;
        if (must_finish) begin
            chk("frame_finished", 32'(frames_exp != f0), 32'd1);
            chk("writes_per_frame", 32'(wr_frame), 32'(FRAME_LEN));
            chk("done_count", 32'(done_seen), 32'(frames_exp));
            repeat (2) step('0, 1'b0, 1'b0, dc, '0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(fifo_bus.fifo_wr_en), 32'd0);
        chk("rst_din", 32'(fifo_bus.fifo_din), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_otr", 32'(otr_flag), 32'd0);
        chk("rst_to", 32'(trig_timeout), 32'd0);
        ad_data = '0; ad_otr = 1'b0; frame_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        t = t + 2;
        model_reset();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ad_data = '0; ad_otr = 1'b0; frame_req = 1'b0; decim = '0;
        trig_level = 8'h80;
        fifo_bus.fifo_wr_count = '0;
        t = 0; frames_exp = 0; done_seen = 0; first_chk_en = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_wr_en", 32'(fifo_bus.fifo_wr_en), 32'd0);
        chk("init_din", 32'(fifo_bus.fifo_din), 32'd0);
        chk("init_done", 32'(frame_done), 32'd0);
        chk("init_otr", 32'(otr_flag), 32'd0);
        chk("init_to", 32'(trig_timeout), 32'd0);
        rst = 1'b0;
        repeat (2) step('0, 1'b0, 1'b0, '0, '0);

`ifdef ADC_FRAME_TRIG_EN
        // rising-edge trigger on a sine, then a mid-capture reset
        run_frame(2, 8'd0, -1, 1'b0, 0, 200, 1'b1);
        run_frame(2, 8'd1, -2, 1'b0, 0, 200, 1'b1);
        run_frame(1, 8'd1, -2, 1'b0, 0, 12, 1'b0);
        do_reset();
        // DC input never crosses the level: forced start by timeout
        run_frame(3, 8'd0, -1, 1'b0, 0, TRIG_TIMEOUT + 200, 1'b1);
        // a triggered frame afterwards clears the timeout flag
        run_frame(2, 8'd2, -1, 1'b0, 0, 300, 1'b1);
`else
        // ramp, no decimation: fifo_din counts 0,1,2,...
        run_frame(0, 8'd0, -1, 1'b0, 0, 100, 1'b1);
        // decimation by 4 on random data
        run_frame(1, 8'd3, -1, 1'b0, 0, 200, 1'b1);
        // FIFO too full: hold in ARM across the exact boundary, then release
        run_frame(1, 8'd0, -1, 1'b0, 30, 200, 1'b1);
        // repeated requests while busy are ignored
        run_frame(1, 8'd2, -1, 1'b1, 0, 200, 1'b1);
        // OTR on written sample 5 only, flag holds after the frame
        run_frame(0, 8'd0, 5, 1'b0, 0, 100, 1'b1);
        repeat (5) step('0, 1'b0, 1'b0, '0, '0);
        // next frame clears the flag
        run_frame(1, 8'd1, -1, 1'b0, 0, 200, 1'b1);
        // random decimation with random OTR
        run_frame(1, DECIM_W'($urandom_range(0, 4)), -2, 1'b0, 0, 300, 1'b1);
        run_frame(1, 8'd0, -2, 1'b0, 0, 100, 1'b1);
        // reset during capture, then a clean frame
        run_frame(1, 8'd1, -2, 1'b0, 0, 12, 1'b0);
        do_reset();
        repeat (2) step('0, 1'b0, 1'b0, '0, '0);
        run_frame(0, 8'd0, -1, 1'b0, 0, 100, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
